// File: rtl/io_pad_pkg.sv
// Shared types and constants for the PB8 pad-group scheduler.
package io_pad_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_IDLE,
        ST_DRIVE,
        ST_TURN,
        ST_SAMPLE
    } state_t;

    typedef enum logic {
        GRANT_TX,
        GRANT_RX
    } grant_t;

    localparam int HOLD_CYC_MIN    = 1;
    localparam int TURN_CYC_MIN    = 1;
    localparam int SYNC_STAGES_MIN = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/io_pad_sched_if.sv
// Requester-side handshake between core I/O port logic and the pad scheduler.
interface io_pad_sched_if #(
    parameter int WIDTH = 8
);
    logic             tx_req;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ack;
    logic             rx_req;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;

    modport master (
        output tx_req, tx_data, rx_req,
        input  tx_ack, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_req, tx_data, rx_req,
        output tx_ack, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/io_pad_sync.sv
// Single-bit flop chain bringing an asynchronous pad C output into clk.
module io_pad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/io_pad_sched.sv
// Sequences a PB8 pad group between a transmit and a receive requester,
// inserting hi-Z turnaround after every drive burst.
//
// state     | meaning
// ST_OFF    | pads powered down (PG=0), waiting for en
// ST_IDLE   | powered, hi-Z, arbitrating tx/rx requests
// ST_DRIVE  | OEN low, pad_i = accepted word, HOLD_CYC cycles per word
// ST_TURN   | hi-Z gap after a drive, TURN_CYC cycles
// ST_SAMPLE | IE high for SYNC_STAGES+1 cycles, capture on last
module io_pad_sched
    import io_pad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYC    = 2,
    parameter int TURN_CYC    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    io_pad_sched_if.slave    req,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_oen,
    output logic [WIDTH-1:0] pad_ie,
    output logic             pad_pg,
    input  logic [WIDTH-1:0] pad_c
);
    // Out-of-range parameters are clamped up to the smallest safe value.
    localparam int HOLD_N  = (HOLD_CYC < HOLD_CYC_MIN) ? HOLD_CYC_MIN : HOLD_CYC;
    localparam int TURN_N  = (TURN_CYC < TURN_CYC_MIN) ? TURN_CYC_MIN : TURN_CYC;
    localparam int SYNC_N  = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_MAX = max3(HOLD_N, TURN_N, SYNC_N + 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'(TURN_N - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LD = CNT_W'(SYNC_N);
    localparam logic [WIDTH-1:0] ALL1      = '1;

    state_t           state;
    grant_t           last_grant;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] rx_data_q;
    logic             tx_ack_q;
    logic             rx_valid_q;
    logic             busy_q;
    logic             tx_win;
    logic             accept_tx;

    for (genvar b = 0; b < WIDTH; b++) begin : g_sync
        io_pad_sync #(.STAGES(SYNC_N)) u_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (pad_c[b]),
            .q     (sync_q[b])
        );
    end

    // tx is taken if rx is not competing, or rx had the previous grant.
    always_comb begin
        tx_win    = req.tx_req && (!req.rx_req || last_grant == GRANT_RX);
        accept_tx = 1'b0;
        if (state == ST_IDLE || (state == ST_DRIVE && cnt == '0))
            accept_tx = tx_win;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            last_grant <= GRANT_RX;
            cnt        <= '0;
            pad_pg     <= 1'b0;
            pad_oen    <= ALL1;
            pad_ie     <= '0;
            pad_i      <= '0;
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            tx_ack_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            if (!en) begin
                state   <= ST_OFF;
                cnt     <= '0;
                pad_pg  <= 1'b0;
                pad_oen <= ALL1;
                pad_ie  <= '0;
                pad_i   <= '0;
                busy_q  <= 1'b0;
            end else if (accept_tx) begin
                state      <= ST_DRIVE;
                cnt        <= HOLD_LD;
                last_grant <= GRANT_TX;
                pad_i      <= req.tx_data;
                pad_oen    <= '0;
                pad_ie     <= '0;
                tx_ack_q   <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state)
                    ST_OFF: begin
                        state  <= ST_IDLE;
                        pad_pg <= 1'b1;
                    end
                    ST_IDLE: begin
                        if (req.rx_req) begin
                            state      <= ST_SAMPLE;
                            cnt        <= SAMPLE_LD;
                            last_grant <= GRANT_RX;
                            pad_ie     <= ALL1;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        if (cnt == '0) begin
                            state   <= ST_TURN;
                            cnt     <= TURN_LD;
                            pad_oen <= ALL1;
                            pad_i   <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_TURN: begin
                        if (cnt == '0) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        if (cnt == '0) begin
                            state      <= ST_IDLE;
                            rx_data_q  <= sync_q;
                            rx_valid_q <= 1'b1;
                            pad_ie     <= '0;
                            busy_q     <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state   <= ST_OFF;
                        pad_pg  <= 1'b0;
                        pad_oen <= ALL1;
                        pad_ie  <= '0;
                        pad_i   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign req.tx_ack   = tx_ack_q;
    assign req.rx_valid = rx_valid_q;
    assign req.rx_data  = rx_data_q;
    assign req.busy     = busy_q;
endmodule

// File: doc/io_pad_sched.md
# io_pad_sched

Controller that sequences a group of PB8 bidirectional pads, sharing them between a transmit requester and a receive requester. It drives the pads' I, OEN, IE and PG controls, and synchronises the pads' C outputs. Between driving and releasing the pads it enforces hi-Z turnaround gaps, so the pads never drive against an external source. It sits between the core's I/O port logic and the stdlib IO pad ring.

## Interface
- WIDTH, 8 — number of pads in the group
- HOLD_CYC, 2 — cycles OEN stays low per transmit word (≥1)
- TURN_CYC, 2 — hi-Z cycles after a drive before release (≥1)
- SYNC_STAGES, 2 — flop stages on each pad_c bit (≥2)

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  reset, asynchronous and active-low.
- en  in  1  pad-group enable; low forces the power-down (OFF) state.
- tx_req  in  1  transmit request; hold until tx_ack.
- tx_data  in  WIDTH  word to drive; sampled on acceptance.
- tx_ack  out  1  one-cycle pulse: word accepted and drive started.
- rx_req  in  1  receive request; hold until rx_valid.
- rx_data  out  WIDTH  captured pad word; held until the next capture.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- busy  out  1  high in every state except IDLE and OFF.
- pad_i  out  WIDTH  to PB8 I.
- pad_oen  out  WIDTH  to PB8 OEN (low = drive).
- pad_ie  out  WIDTH  to PB8 IE.
- pad_pg  out  1  to PB8 PG, shared by all pads.
- pad_c  in  WIDTH  from PB8 C; asynchronous.

## Operation
States: OFF, IDLE, DRIVE, TURN, SAMPLE. All pad controls are registered; each state has fixed pad-control values.
- OFF: pad_pg=0, pad_oen=all 1, pad_ie=0, pad_i=0.
  - Leaves for IDLE on the first edge with en=1.
- IDLE: pad_pg=1, pad_oen=all 1, pad_ie=0.
  - Arbitration when one request is pending: that request is granted.
  - When both are pending: round-robin, tracked by the last_grant register. After reset, tx wins first.
- Grant tx: tx_data is latched and tx_ack pulses. Next state is DRIVE, with pad_oen=0 and pad_i=latched word for HOLD_CYC cycles.
- At the end of DRIVE:
  - If tx_req is high and last_grant permits tx, the next word is accepted (tx_ack pulses) and DRIVE restarts with no gap.
  - Otherwise the FSM enters TURN: pad_oen=all 1, pad_ie=0 for TURN_CYC cycles, then IDLE.
- Grant rx: SAMPLE with pad_ie=all 1 for SYNC_STAGES+1 cycles.
  - On the last cycle, rx_data is loaded from the synchroniser output and rx_valid pulses. The FSM then returns to IDLE.
- en low in any state: OFF on the next edge.
  - An aborted DRIVE keeps its already-given ack.
  - An aborted SAMPLE produces no rx_valid; the pending rx_req is serviced after re-enable.
- pad_oen=0 and pad_ie=1 are never asserted in the same cycle.

## Timing
- Reset values:
  - State OFF.
  - pad_pg=0, pad_oen=all 1, pad_ie=0, pad_i=0.
  - tx_ack=0, rx_valid=0, rx_data=0, busy=0.
  - last_grant=rx, so the first contended grant goes to tx.
- en=1 at edge k gives pad_pg=1 after edge k.
- tx_req seen in IDLE at edge k:
  - tx_ack is high for the cycle after edge k.
  - pad_oen=0 for cycles k..k+HOLD_CYC−1.
  - TURN follows; IDLE is reached at k+HOLD_CYC+TURN_CYC.
- rx_req seen in IDLE at edge k:
  - pad_ie=1 after edge k.
  - rx_valid is high after edge k+SYNC_STAGES+1.
  - The FSM is back in IDLE on that same edge.
- The pad_c synchroniser runs continuously. Pad values must be stable from edge k+1 until capture.
- A request that rises during a non-IDLE state waits. There is no queueing beyond the held request level.
- If tx_req and en fall on the same edge, en wins.

## Structure
- Package io_pad_pkg holds the state enum (OFF, IDLE, DRIVE, TURN, SAMPLE), the grant encoding (TX, RX) and the parameter lower-bound constants.
- Sub-module io_pad_sync is the per-bit SYNC_STAGES flop chain, instantiated WIDTH times. It uses the same clk/rst_n and resets to 0.
- Everything else lives in io_pad_sched: FSM, hold/turn counter sized to the maximum of HOLD_CYC, TURN_CYC and SYNC_STAGES+1, data latch and last_grant.

## Test plan
- Reset/enable: assert rst_n=0 mid-run → outputs at reset values immediately. Then en=1 → pad_pg=1 one cycle later, with pad_oen=FF and pad_ie=00.
- Single tx: tx_data=0xA5 with defaults → tx_ack 1 cycle; pad_oen=00 and pad_i=A5 for 2 cycles; pad_oen=FF for 2 cycles; busy low at cycle 4.
- Back-to-back tx: 0x3C then 0xC3 with tx_req held → pad_oen low for 4 consecutive cycles with no hi-Z gap; two tx_ack pulses.
- Rx: pad_c driven to 0x5A, rx_req → rx_valid 3 cycles after grant, rx_data=5A; pad_ie=FF only during SAMPLE.
- Contention: tx_req and rx_req high together from reset, both held → grant order tx, rx, tx, rx; TURN always separates DRIVE from SAMPLE. Check that pad_oen=0 and pad_ie=1 never coincide.
- Power-down: drop en mid-SAMPLE → OFF next cycle with no rx_valid. Re-raise en → rx served and rx_valid delivered.
